// File: rtl/elixirchip_es1_spu_mac_dot_ctrl_if.sv
// Signal bundle between the dot-product controller, its operand source, the MAC and the result sink.
// slave = controller view, master = surrounding-environment view.
interface elixirchip_es1_spu_mac_dot_ctrl_if #(
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 9,
  parameter int M_DATA_BITS  = 10,
  parameter int COUNT_BITS   = 16
);
  logic [S_DATA0_BITS-1:0] s_data0;
  logic [S_DATA1_BITS-1:0] s_data1;
  logic                    s_sub;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;

  logic                    mac_set;
  logic                    mac_sub;
  logic [S_DATA0_BITS-1:0] mac_data0;
  logic [S_DATA1_BITS-1:0] mac_data1;
  logic                    mac_valid;
  logic [M_DATA_BITS-1:0]  mac_m_data;

  logic [M_DATA_BITS-1:0]  m_data;
  logic [COUNT_BITS-1:0]   m_count;
  logic                    m_valid;
  logic                    m_ready;

  modport slave (
    input  s_data0, s_data1, s_sub, s_last, s_valid,
    output s_ready,
    output mac_set, mac_sub, mac_data0, mac_data1, mac_valid,
    input  mac_m_data,
    output m_data, m_count, m_valid,
    input  m_ready
  );

  modport master (
    output s_data0, s_data1, s_sub, s_last, s_valid,
    input  s_ready,
    input  mac_set, mac_sub, mac_data0, mac_data1, mac_valid,
    output mac_m_data,
    input  m_data, m_count, m_valid,
    output m_ready
  );
endinterface

// File: rtl/elixirchip_es1_spu_mac_dot_ctrl.sv
// Dot-product controller: issues operand pairs to the MAC, waits out its latency after the
// last element and holds the accumulated result plus element count on a valid/ready port.
module elixirchip_es1_spu_mac_dot_ctrl #(
  parameter int LATENCY      = 3,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 9,
  parameter int M_DATA_BITS  = 10,
  parameter int COUNT_BITS   = 16
) (
  input logic reset,
  input logic clk,
  input logic cke,
  elixirchip_es1_spu_mac_dot_ctrl_if.slave bus
);
  localparam int DCNT_BITS = $clog2(LATENCY + 1);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]              state;
  logic                    first;
  logic [DCNT_BITS-1:0]    dcnt;
  logic [COUNT_BITS-1:0]   count;

  logic                    mac_set;
  logic                    mac_sub;
  logic [S_DATA0_BITS-1:0] mac_data0;
  logic [S_DATA1_BITS-1:0] mac_data1;
  logic                    mac_valid;
  logic [M_DATA_BITS-1:0]  m_data;
  logic [COUNT_BITS-1:0]   m_count;
  logic                    m_valid;

  logic s_ready;
  logic accept;
  logic drain_done;
  logic capture;

  assign s_ready    = cke & ~reset & (state == ACCUM);
  assign accept     = bus.s_valid & s_ready;
  assign drain_done = ((state == DRAIN) && (dcnt == '0)) || (state == WAIT);
  // A pending result may be replaced on the same edge it is consumed.
  assign capture    = cke & drain_done & (~m_valid | bus.m_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      first     <= 1'b1;
      dcnt      <= '0;
      count     <= '0;
      mac_set   <= 1'b0;
      mac_sub   <= 1'b0;
      mac_data0 <= '0;
      mac_data1 <= '0;
      mac_valid <= 1'b0;
      m_data    <= '0;
      m_count   <= '0;
      m_valid   <= 1'b0;
    end else if (cke) begin
      mac_valid <= accept;
      if (accept) begin
        mac_data0 <= bus.s_data0;
        mac_data1 <= bus.s_data1;
        mac_sub   <= bus.s_sub;
        mac_set   <= first;
        first     <= bus.s_last;
        if (first)
          count <= COUNT_BITS'(1);
        else if (count != '1)
          count <= count + COUNT_BITS'(1);
      end

      case (state)
        ACCUM: begin
          if (accept && bus.s_last) begin
            state <= DRAIN;
            dcnt  <= DCNT_BITS'(LATENCY);
          end
        end
        DRAIN: begin
          if (dcnt != '0)
            dcnt <= dcnt - DCNT_BITS'(1);
          else if (capture)
            state <= ACCUM;
          else
            state <= WAIT;
        end
        WAIT: begin
          if (capture)
            state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase

      if (capture) begin
        m_data  <= bus.mac_m_data;
        m_count <= count;
        m_valid <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.mac_set   = mac_set;
  assign bus.mac_sub   = mac_sub;
  assign bus.mac_data0 = mac_data0;
  assign bus.mac_data1 = mac_data1;
  assign bus.mac_valid = mac_valid;
  assign bus.m_data    = m_data;
  assign bus.m_count   = m_count;
  assign bus.m_valid   = m_valid;
endmodule

// File: tb/tb_elixirchip_es1_spu_mac_dot_ctrl.sv
// Directed bench for the dot-product controller with a behavioural MAC stand-in.
module tb_elixirchip_es1_spu_mac_dot_ctrl;
  localparam int LATENCY = 3;
  localparam int S0 = 8;
  localparam int S1 = 9;
  localparam int MB = 10;
  localparam int CB = 16;
  localparam int NTBL = 11;

  typedef struct {
    logic [S0-1:0] d0;
    logic [S1-1:0] d1;
    logic          sub;
    logic          last;
    logic [MB-1:0] exp_data;
    logic [CB-1:0] exp_cnt;
  } elem_t;

  typedef struct {
    logic [MB-1:0] d;
    logic [CB-1:0] c;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic cke;
  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  elem_t tbl [NTBL];

  elixirchip_es1_spu_mac_dot_ctrl_if #(
    .S_DATA0_BITS(S0), .S_DATA1_BITS(S1), .M_DATA_BITS(MB), .COUNT_BITS(CB)
  ) bus ();

  elixirchip_es1_spu_mac_dot_ctrl #(
    .LATENCY(LATENCY), .S_DATA0_BITS(S0), .S_DATA1_BITS(S1),
    .M_DATA_BITS(MB), .COUNT_BITS(CB)
  ) u_dut (
    .reset(reset),
    .clk  (clk),
    .cke  (cke),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // MAC stand-in: accumulator followed by LATENCY-1 delay stages, all cke-gated.
  logic signed [S0+S1-1:0] prod;
  logic [MB-1:0] prod_t;
  logic [MB-1:0] term;
  logic [MB-1:0] pipe [LATENCY];
  assign prod   = $signed(bus.mac_data0) * $signed(bus.mac_data1);
  assign prod_t = prod[MB-1:0];
  assign term   = bus.mac_sub ? -prod_t : prod_t;
  assign bus.mac_m_data = pipe[LATENCY-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (cke) begin
      if (bus.mac_valid) pipe[0] <= bus.mac_set ? term : pipe[0] + term;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic elem_t mk(int d0, int d1, bit sub, bit last, int ed, int ec);
    elem_t r;
    r.d0 = S0'(d0);
    r.d1 = S1'(d1);
    r.sub = sub;
    r.last = last;
    r.exp_data = MB'(ed);
    r.exp_cnt = CB'(ec);
    return r;
  endfunction

  // Issue-port and result-port monitor, sampling on the falling edge.
  initial begin : monitor
    bit have_prev = 0;
    bit p_reset = 0, p_cke = 0, p_acc = 0;
    bit tb_first = 1;
    logic e_set, e_sub;
    logic [S0-1:0] e_d0;
    logic [S1-1:0] e_d1;
    res_t r;
    forever begin
      @(negedge clk);
      if (have_prev) begin
        if (p_reset) begin
          chk("mac_valid_after_reset", bus.mac_valid, 0);
        end else if (p_cke) begin
          chk("mac_valid", bus.mac_valid, p_acc);
          if (p_acc) begin
            chk("mac_set", bus.mac_set, e_set);
            chk("mac_sub", bus.mac_sub, e_sub);
            chk("mac_data0", bus.mac_data0, e_d0);
            chk("mac_data1", bus.mac_data1, e_d1);
          end
        end
      end
      if (!cke) chk("s_ready_cke0", bus.s_ready, 0);
      if (cke && !reset && bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("m_data", bus.m_data, r.d);
          chk("m_count", bus.m_count, r.c);
        end
      end
      have_prev = 1;
      p_reset = reset;
      p_cke = cke;
      p_acc = cke && bus.s_valid && bus.s_ready;
      if (p_acc) begin
        e_set = tb_first;
        e_sub = bus.s_sub;
        e_d0 = bus.s_data0;
        e_d1 = bus.s_data1;
        tb_first = bus.s_last;
      end
      if (reset) tb_first = 1;
    end
  end

  // All driving tasks start and end just after a rising edge.
  task automatic put(input elem_t e, input bit gaps);
    bit ok = 0;
    int unsigned n = 0;
    while (!ok && n < 300) begin
      bus.s_data0 = e.d0;
      bus.s_data1 = e.d1;
      bus.s_sub = e.sub;
      bus.s_last = e.last;
      if (gaps) begin
        cke = ($urandom_range(0, 3) != 0);
        bus.s_valid = ($urandom_range(0, 2) != 0);
        bus.m_ready = $urandom_range(0, 1);
      end else begin
        cke = 1;
        bus.s_valid = 1;
      end
      @(negedge clk);
      ok = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    if (ok && e.last) exp_q.push_back('{d: e.exp_data, c: e.exp_cnt});
  endtask

  task automatic idle(input int unsigned n, input bit gaps);
    for (int unsigned i = 0; i < n; i++) begin
      bus.s_valid = 0;
      if (gaps) begin
        cke = ($urandom_range(0, 3) != 0);
        bus.m_ready = $urandom_range(0, 1);
      end else begin
        cke = 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drained();
    int unsigned n = 0;
    cke = 1;
    bus.m_ready = 1;
    bus.s_valid = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : main
    tbl[0]  = mk(2, 3, 0, 0, 0, 0);
    tbl[1]  = mk(4, 5, 0, 0, 0, 0);
    tbl[2]  = mk(-1, 7, 0, 1, 19, 3);
    tbl[3]  = mk(10, 10, 0, 0, 0, 0);
    tbl[4]  = mk(3, 4, 1, 1, 88, 2);
    tbl[5]  = mk(-8, -16, 0, 1, 128, 1);
    tbl[6]  = mk(127, 255, 0, 1, 641, 1);
    tbl[7]  = mk(-128, -256, 0, 1, 0, 1);
    tbl[8]  = mk(-128, 255, 0, 0, 0, 0);
    tbl[9]  = mk(5, -3, 1, 1, 143, 2);
    tbl[10] = mk(0, 0, 0, 1, 0, 1);

    reset = 1;
    cke = 1;
    bus.s_valid = 0;
    bus.s_data0 = '0;
    bus.s_data1 = '0;
    bus.s_sub = 0;
    bus.s_last = 0;
    bus.m_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_count", bus.m_count, 0);
    chk("reset_m_data", bus.m_data, 0);
    chk("reset_s_ready", bus.s_ready, 0);
    chk("reset_mac_set", bus.mac_set, 0);
    chk("reset_mac_data0", bus.mac_data0, 0);
    @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1;

    // Reference run, cke held high, result consumed immediately.
    for (int i = 0; i < NTBL; i++) begin
      put(tbl[i], 0);
      if (i == 2) begin
        for (int j = 0; j <= LATENCY + 1; j++) begin
          @(negedge clk);
          chk("latency_m_valid", bus.m_valid, (j == LATENCY + 1) ? 1 : 0);
          @(posedge clk);
          #1;
        end
      end
    end
    wait_drained();

    // Back-to-back vectors with the sink stalled: the second one parks in WAIT.
    bus.m_ready = 0;
    for (int i = 0; i <= 4; i++) put(tbl[i], 0);
    idle(20, 0);
    @(negedge clk);
    chk("wait_m_valid", bus.m_valid, 1);
    chk("wait_m_data_hold", bus.m_data, 19);
    chk("wait_m_count_hold", bus.m_count, 3);
    chk("wait_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1 bus.m_ready = 1;
    @(posedge clk);
    #1 bus.m_ready = 0;
    @(negedge clk);
    chk("swap_m_valid", bus.m_valid, 1);
    chk("swap_m_data", bus.m_data, 88);
    chk("swap_m_count", bus.m_count, 2);
    @(posedge clk);
    #1;
    wait_drained();

    // Same vectors with random cke gaps, bubbles and sink stalls.
    for (int i = 0; i < NTBL; i++) begin
      put(tbl[i], 1);
      idle($urandom_range(0, 3), 1);
    end
    wait_drained();

    // Reset while draining discards the vector.
    put(mk(5, 5, 0, 1, 25, 1), 0);
    idle(1, 0);
    reset = 1;
    @(negedge clk);
    chk("reset_cycle_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1 reset = 0;
    exp_q.delete();
    @(negedge clk);
    chk("post_reset_m_valid", bus.m_valid, 0);
    chk("post_reset_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
    idle(8, 0);
    put(mk(1, 1, 0, 1, 1, 1), 0);
    wait_drained();
    idle(4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
